// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader.
//   XLEN            : instruction word width (fixed at 32)
//   loader_state_t  : loader FSM states
//   BYTES_PER_WORD,
//   LANE_W,
//   lane_lsb()      : byte-lane geometry of a little-endian word
package riscv_pkg;

    localparam int XLEN           = 32;
    localparam int LANE_W         = 8;
    localparam int BYTES_PER_WORD = XLEN / LANE_W;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5
    } loader_state_t;

    // Bit position of byte lane 'lane' within a word; lane 0 is the first byte received.
    function automatic int lane_lsb(input int lane);
        return lane * LANE_W;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   s_valid/s_data/s_ready : host byte link, valid/ready handshake
//   mem_we/mem_addr/mem_wdata : instruction memory write port
// Modports:
//   slave  : the loader (consumes bytes, drives the memory port)
//   master : the host/memory side
interface imem_loader_if
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles four consecutive bytes into one little-endian 32-bit word.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   byte_in   : byte to store
//   byte_en   : store byte_in into the next free lane
//   clear     : restart filling at lane 0 (lane contents are kept)
//   word_out  : packed word, first byte in [7:0]
//   full      : all four lanes hold bytes of the current word
module word_packer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      byte_in,
    input  logic            byte_en,
    input  logic            clear,
    output logic [XLEN-1:0] word_out,
    output logic            full
);
    localparam logic [2:0] FULL_COUNT = 3'(BYTES_PER_WORD);

    logic [2:0] count_reg;

    assign full = (count_reg == FULL_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (byte_en && !full) begin
            count_reg <= count_reg + 3'd1;
        end
    end

    // One register per lane; the fill count selects which lane takes the byte.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        logic [LANE_W-1:0] lane_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg <= '0;
            end else if (byte_en && !full && !clear && (count_reg == 3'(gi))) begin
                lane_reg <= byte_in;
            end
        end

        assign word_out[lane_lsb(gi) +: LANE_W] = lane_reg;
    end

endmodule

// File: rtl/imem_loader.sv
// Runtime loader for the instruction memory. Receives a frame
//   LEN_lo, LEN_hi, 4*LEN data bytes [, checksum byte]
// over a byte handshake, packs the data into little-endian words and writes
// them to consecutive word addresses starting at 0. The core is held in
// reset until the whole frame has been consumed.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   io          : imem_loader_if.slave (byte stream in, memory write port out)
//   core_rst    : reset to the core, released when the load completes
//   done        : load complete, sticky until rst
//   err         : sticky error (word beyond memory depth, or bad checksum)
//   word_count  : words processed so far (including dropped ones)
// Optional build macro:
//   IMEM_LOADER_CHECKSUM_EN : expect one trailing byte equal to the XOR of
//                             all data bytes; a mismatch sets err.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave io,
    output logic         core_rst,
    output logic         done,
    output logic         err,
    output logic [15:0]  word_count
);
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    loader_state_t   state_reg;
    logic            s_ready_reg;
    logic            core_rst_reg;
    logic            done_reg;
    logic            err_reg;
    logic [15:0]     word_count_reg;
    logic [15:0]     len_reg;
    logic [1:0]      byte_idx_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum_reg;
`endif

    logic            xfer;
    logic            in_range;
    logic            last_word;
    logic            pack_en;
    logic            pack_clear;
    logic            pack_full;
    logic [XLEN-1:0] pack_word;

    assign xfer       = io.s_valid && s_ready_reg;
    assign in_range   = ({1'b0, word_count_reg} < DEPTH);
    assign last_word  = ((word_count_reg + 16'd1) == len_reg);
    assign pack_en    = xfer && (state_reg == DATA);
    assign pack_clear = (state_reg == LEN_HI) || (state_reg == WRITE);

    word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .byte_in  (io.s_data),
        .byte_en  (pack_en),
        .clear    (pack_clear),
        .word_out (pack_word),
        .full     (pack_full)
    );

    // The packer holds the word steady through the WRITE cycle, so the
    // memory port is driven straight from registers. Qualifying with
    // pack_full guarantees a partially assembled word is never written.
    assign io.s_ready   = s_ready_reg;
    assign io.mem_we    = (state_reg == WRITE) && pack_full && in_range;
    assign io.mem_addr  = word_count_reg[ADDR_W-1:0];
    assign io.mem_wdata = pack_word;

    assign core_rst   = core_rst_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign word_count = word_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LEN_LO;
            s_ready_reg    <= 1'b0;
            core_rst_reg   <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            word_count_reg <= '0;
            len_reg        <= '0;
            byte_idx_reg   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                LEN_LO: begin
                    s_ready_reg <= 1'b1;
                    if (xfer) begin
                        len_reg[7:0] <= io.s_data;
                        state_reg    <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (xfer) begin
                        len_reg[15:8] <= io.s_data;
                        byte_idx_reg  <= '0;
                        if ({io.s_data, len_reg[7:0]} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            // Empty frame still carries a checksum byte (expected 0x00).
                            state_reg    <= CHK;
`else
                            state_reg    <= DONE;
                            s_ready_reg  <= 1'b0;
                            done_reg     <= 1'b1;
                            core_rst_reg <= 1'b0;
`endif
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg     <= csum_reg ^ io.s_data;
`endif
                        if (byte_idx_reg == 2'd3) begin
                            state_reg   <= WRITE;
                            s_ready_reg <= 1'b0;
                        end
                    end
                end

                WRITE: begin
                    // Out-of-range words are dropped but still counted so the
                    // frame length bookkeeping stays aligned with the host.
                    if (!in_range) begin
                        err_reg <= 1'b1;
                    end
                    word_count_reg <= word_count_reg + 16'd1;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_reg    <= CHK;
                        s_ready_reg  <= 1'b1;
`else
                        state_reg    <= DONE;
                        s_ready_reg  <= 1'b0;
                        done_reg     <= 1'b1;
                        core_rst_reg <= 1'b0;
`endif
                    end else begin
                        state_reg   <= DATA;
                        s_ready_reg <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        if (io.s_data != csum_reg) begin
                            err_reg <= 1'b1;
                        end
                        // The core is released regardless; err is for the host.
                        state_reg    <= DONE;
                        s_ready_reg  <= 1'b0;
                        done_reg     <= 1'b1;
                        core_rst_reg <= 1'b0;
                    end
                end
`endif

                DONE: begin
                    s_ready_reg <= 1'b0;
                end

                default: begin
                    state_reg <= LEN_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2, DEPTH=4 so overflow is reachable).
// Stimulus builds whole frames; the expected memory writes are pushed to a
// queue and a negedge monitor pops and compares every mem_we it sees.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum option.
module tb_imem_loader;
    import riscv_pkg::*;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (bus),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    wr_t         exp_q[$];
    logic [31:0] mem_dut [DEPTH];
    logic [31:0] mem_ref [DEPTH];
    int          we_count;
    int          first_we_cyc;
    int          last_we_cyc;
    bit          done_seen;
    int          done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: the bench acts as the instruction memory and scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (bus.mem_we) begin
                mem_dut[bus.mem_addr] = bus.mem_wdata;
                if (we_count == 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
                we_count++;
                chk("s_ready_low_in_write", 32'(bus.s_ready), 32'd0);
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("write_data", bus.mem_wdata, e.data);
                end
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    // acc_cyc is the cycle number of the accepting clock edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        for (int i = 0; i < gap; i++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        acc_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                @(posedge clk); #1;
                acc_cyc = cyc;
                break;
            end
        end
        chk("byte_accepted", 32'(acc_cyc >= 0), 32'd1);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_s_ready",    32'(bus.s_ready),   32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",   32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,      32'd0);
        chk("rst_core_rst",   32'(core_rst),      32'd1);
        chk("rst_done",       32'(done),          32'd0);
        chk("rst_err",        32'(err),           32'd0);
        chk("rst_word_count", 32'(word_count),    32'd0);
        exp_q.delete();
        we_count  = 0;
        done_seen = 1'b0;
        rst = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    // gap_mode: 0 back-to-back, 1 s_valid toggling, 2 random gaps.
    task automatic run_frame(input byte_q_t payload, input int gap_mode, input bit bad_csum);
        int          len;
        int          acc;
        int          hi_acc;
        int          first_word_acc;
        int          last_data_acc;
        int          exp_done_cyc;
        int          exp_writes;
        bit          exp_err;
        logic [7:0]  x;
        logic [31:0] word;
        wr_t         e;
        logic [15:0] len16;
        int          wc_before;

        len            = payload.size() / 4;
        len16          = 16'(len);
        x              = 8'h00;
        first_word_acc = -1;
        last_data_acc  = -1;

        // Reference model: words from little-endian byte groups, writes only
        // for addresses inside the memory, err when any word falls outside.
        for (int w = 0; w < len; w++) begin
            word = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
            if (w < DEPTH) begin
                e.addr = AW'(w);
                e.data = word;
                exp_q.push_back(e);
                mem_ref[w] = word;
            end
        end
        foreach (payload[i]) x = x ^ payload[i];
        exp_err    = (len > DEPTH);
        exp_writes = (len < DEPTH) ? len : DEPTH;

        send_byte(len16[7:0], pick_gap(gap_mode), acc);
        send_byte(len16[15:8], pick_gap(gap_mode), hi_acc);
        foreach (payload[i]) begin
            send_byte(payload[i], pick_gap(gap_mode), acc);
            if (i == 3) first_word_acc = acc;
            last_data_acc = acc;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (x ^ 8'h01) : x, pick_gap(gap_mode), acc);
        exp_err      = exp_err || bad_csum;
        exp_done_cyc = acc;
`else
        exp_done_cyc = (len == 0) ? hi_acc : last_data_acc + 1;
`endif

        for (int n = 0; n < 100 && !done_seen; n++) @(negedge clk);
        @(negedge clk);
        chk("done_reached",     32'(done_seen),  32'd1);
        chk("done_cycle",       32'(done_cyc),   32'(exp_done_cyc));
        chk("done",             32'(done),       32'd1);
        chk("core_rst",         32'(core_rst),   32'd0);
        chk("err",              32'(err),        32'(exp_err));
        chk("word_count",       32'(word_count), 32'(len));
        chk("write_pulses",     32'(we_count),   32'(exp_writes));
        chk("writes_left",      32'(exp_q.size()), 32'd0);
        if (len > 0) begin
            chk("first_write_latency", 32'(first_we_cyc), 32'(first_word_acc));
        end
        for (int a = 0; a < DEPTH; a++) begin
            chk($sformatf("mem[%0d]", a), mem_dut[a], mem_ref[a]);
        end

        // After DONE further bytes must be back-pressured.
        wc_before   = we_count;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("done_backpressure", 32'(bus.s_ready), 32'd0);
        chk("done_no_more_writes", 32'(we_count), 32'(wc_before));
        chk("done_sticky", 32'(done), 32'd1);
        bus.s_valid = 1'b0;

        $display("frame len=%0d gap_mode=%0d bad_csum=%0b writes=%0d err=%0b done_cycle=%0d",
                 len, gap_mode, bad_csum, we_count, err, done_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t p;
        int      acc;
        int      len;

        for (int a = 0; a < DEPTH; a++) begin
            mem_dut[a] = 32'hDEAD_0000 + 32'(a);
            mem_ref[a] = 32'hDEAD_0000 + 32'(a);
        end
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        we_count    = 0;
        done_seen   = 1'b0;
        do_reset();

        // Two-word program, back-to-back bytes.
        p = {8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_frame(p, 0, 1'b0);
        chk("prog_word0", mem_dut[0], 32'h00A00513);
        chk("prog_word1", mem_dut[1], 32'h00100593);

        // Empty frame.
        do_reset();
        p = {};
        run_frame(p, 0, 1'b0);

        // s_valid toggling every cycle.
        do_reset();
        p = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(p, 1, 1'b0);
        chk("toggle_word0", mem_dut[0], 32'hEFBEADDE);

        // Overflow: LEN=5 into a 4-word memory.
        do_reset();
        p = {};
        for (int i = 0; i < 20; i++) p.push_back(8'($urandom));
        run_frame(p, 2, 1'b0);

        // Abort mid-frame with reset, then a fresh one-word load.
        do_reset();
        send_byte(8'h03, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'($urandom), 0, acc);
        send_byte(8'($urandom), 0, acc);
        chk("no_write_before_abort", 32'(we_count), 32'd0);
        do_reset();
        p = {8'h37, 8'h15, 8'h00, 8'h00};
        run_frame(p, 0, 1'b0);
        chk("after_abort_word0", mem_dut[0], 32'h00001537);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        p = {8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(p, 0, 1'b0);
        do_reset();
        run_frame(p, 0, 1'b1);
`endif

        // Randomised frames.
        for (int t = 0; t < 12; t++) begin
            do_reset();
            len = int'($urandom_range(0, 6));
            p = {};
            for (int i = 0; i < 4 * len; i++) p.push_back(8'($urandom));
            run_frame(p, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
